// File: rtl/uart_image_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_image_loader
// Brief    : UART 8N1 receiver that streams one image of pixels into the
//            network input memory, then pulses nn_start and waits for nn_done.
//            Optional macro LOAD_TIMEOUT_EN abandons a stalled partial frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_image_loader #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int NUM_PIXELS     = 784,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  uart_rx,
  input  logic                  nn_done,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [7:0]            mem_wr_data,
  output logic                  nn_start,
  output logic                  busy,
  output logic                  framing_error,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]      FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]      HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX  = ADDR_WIDTH'(NUM_PIXELS - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] L_LOAD  = 2'd0;
  localparam logic [1:0] L_START = 2'd1;
  localparam logic [1:0] L_WAIT  = 2'd2;

  logic             sync1, rx_s;
  logic [1:0]       rx_state, rx_next;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             wait_high;
  logic             half_tick, full_tick, stop_tick, stop_good;
  logic             byte_valid;

  logic [1:0]            l_state, l_next;
  logic [ADDR_WIDTH-1:0] pix_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rx_s  <= sync1;
    end
  end

  // ---------------- RX FSM ----------------
  always_ff @(posedge clk) begin
    if (!resetn) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_s) rx_next = RX_START;
      RX_START: if (half_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_tick && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (wait_high) begin
          if (rx_s) rx_next = RX_IDLE;
        end else if (stop_tick && rx_s) begin
          rx_next = RX_IDLE;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    half_tick = (rx_state == RX_START) && (clk_cnt == HALF_LAST);
    full_tick = (clk_cnt == FULL_LAST);
    stop_tick = (rx_state == RX_STOP) && !wait_high && full_tick;
    stop_good = stop_tick && rx_s;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_cnt       <= '0;
      bit_idx       <= 3'd0;
      shift_reg     <= 8'h00;
      wait_high     <= 1'b0;
      framing_error <= 1'b0;
      byte_valid    <= 1'b0;
    end else begin
      byte_valid <= stop_good;
      case (rx_state)
        RX_IDLE: begin
          clk_cnt   <= '0;
          bit_idx   <= 3'd0;
          wait_high <= 1'b0;
        end
        RX_START: clk_cnt <= half_tick ? '0 : clk_cnt + 1'b1;
        RX_DATA: begin
          if (full_tick) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          // A low stop bit parks here until the line returns to idle.
          if (!wait_high) begin
            clk_cnt <= full_tick ? '0 : clk_cnt + 1'b1;
            if (stop_tick && !rx_s) begin
              wait_high     <= 1'b1;
              framing_error <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // ---------------- Loader FSM ----------------
  always_ff @(posedge clk) begin
    if (!resetn) l_state <= L_LOAD;
    else         l_state <= l_next;
  end

  always_comb begin
    l_next = l_state;
    case (l_state)
      L_LOAD:  if (byte_valid && pix_cnt == LAST_PIX) l_next = L_START;
      L_START: l_next = L_WAIT;
      L_WAIT:  if (nn_done) l_next = L_LOAD;
      default: l_next = L_LOAD;
    endcase
  end

  always_comb begin
    mem_wr_en   = (l_state == L_LOAD) && byte_valid;
    mem_wr_addr = pix_cnt;
    mem_wr_data = shift_reg;
    nn_start    = (l_state == L_START);
  end

`ifdef LOAD_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout;

  assign timeout = (l_state == L_LOAD) && (pix_cnt != '0) && !byte_valid &&
                   (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (!resetn || l_state != L_LOAD || pix_cnt == '0 || byte_valid)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  logic timeout;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pix_cnt <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (mem_wr_en) begin
        busy    <= 1'b1;
        pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
      end else if (timeout) begin
        busy    <= 1'b0;
        pix_cnt <= '0;
      end
      if (l_state == L_WAIT && nn_done) busy <= 1'b0;
      if (byte_valid && l_state != L_LOAD) overrun <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_image_loader.sv
`default_nettype none
// Testbench for uart_image_loader: directed vector table plus hand-written
// multi-cycle sequences (frame timing, glitch, reset, optional timeout).
module tb_uart_image_loader;
  localparam int CPB = 4;
  localparam int NPIX = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic uart_rx = 1'b1;
  logic done_man = 1'b0;
  logic done_inj = 1'b0;
  logic nn_done;
  logic mem_wr_en, nn_start, busy, framing_error, overrun;
  logic [AW-1:0] mem_wr_addr;
  logic [7:0] mem_wr_data;

  assign nn_done = done_man | done_inj;

  uart_image_loader #(
    .CLKS_PER_BIT(CPB), .NUM_PIXELS(NPIX), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .resetn(resetn), .uart_rx(uart_rx), .nn_done(nn_done),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .nn_start(nn_start), .busy(busy), .framing_error(framing_error),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_count = 0;
  int start_count = 0;
  int last_wr_cyc = 0;
  int last_start_cyc = 0;
  logic [AW-1:0] log_addr [0:255];
  logic [7:0]    log_data [0:255];
  logic inject = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    done_inj = 1'b0;
    if (mem_wr_en) begin
      check("addr_in_range", 32'(mem_wr_addr < AW'(NPIX - 1) || mem_wr_addr == AW'(NPIX - 1)), 32'd1);
      log_addr[wr_count[7:0]] = mem_wr_addr;
      log_data[wr_count[7:0]] = mem_wr_data;
      wr_count++;
      last_wr_cyc = cyc;
    end
    if (nn_start) begin
      start_count++;
      last_start_cyc = cyc;
      if (inject) begin
        done_inj = 1'b1;
        inject = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_ok);
    logic [7:0] b;
    b = d;
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_ok;
    tick(CPB);
    uart_rx = 1'b1;
    tick(stop_ok ? 4 : 2 * CPB);
  endtask

  task automatic pulse_done();
    done_man = 1'b1;
    tick(1);
    done_man = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(2);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       pre_done;
    logic       exp_wr;
    logic [AW-1:0] exp_addr;
    logic [7:0] exp_data;
    logic       exp_busy;
    int         exp_starts;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t vecs [0:6];

  initial begin
    int w0, s0;
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 2'd0, 8'hA5, 1'b1, 0, 1'b0, 1'b0};
    vecs[1] = '{8'h02, 1'b1, 1'b0, 1'b1, 2'd1, 8'h02, 1'b1, 0, 1'b0, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 0, 1'b1, 1'b0};
    vecs[3] = '{8'h66, 1'b1, 1'b0, 1'b1, 2'd2, 8'h66, 1'b1, 0, 1'b1, 1'b0};
    vecs[4] = '{8'h04, 1'b1, 1'b0, 1'b1, 2'd3, 8'h04, 1'b1, 1, 1'b1, 1'b0};
    vecs[5] = '{8'h77, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1, 1'b1, 1'b1};
    vecs[6] = '{8'h10, 1'b1, 1'b1, 1'b1, 2'd0, 8'h10, 1'b1, 1, 1'b1, 1'b1};

    resetn = 1'b0;
    tick(3);
    check("reset_outputs",
          {25'd0, mem_wr_en, mem_wr_addr, nn_start, busy, framing_error, overrun}, 32'd0);
    check("reset_data", 32'(mem_wr_data), 32'd0);
    resetn = 1'b1;
    tick(2);

    s0 = start_count;
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].pre_done) begin
        pulse_done();
        check($sformatf("v%0d_busy_after_done", v), 32'(busy), 32'd0);
      end
      w0 = wr_count;
      send_byte(vecs[v].data, vecs[v].stop_ok);
      check($sformatf("v%0d_writes", v), 32'(wr_count - w0), 32'(vecs[v].exp_wr));
      if (vecs[v].exp_wr) begin
        check($sformatf("v%0d_addr", v), 32'(log_addr[w0[7:0]]), 32'(vecs[v].exp_addr));
        check($sformatf("v%0d_data", v), 32'(log_data[w0[7:0]]), 32'(vecs[v].exp_data));
      end
      check($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
      check($sformatf("v%0d_starts", v), 32'(start_count - s0), 32'(vecs[v].exp_starts));
      check($sformatf("v%0d_framing", v), 32'(framing_error), 32'(vecs[v].exp_fe));
      check($sformatf("v%0d_overrun", v), 32'(overrun), 32'(vecs[v].exp_ov));
    end

    // Full frame with nn_done pulsed exactly on the nn_start cycle (ignored).
    do_reset();
    w0 = wr_count;
    s0 = start_count;
    inject = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("frame_addr%0d", i), 32'(log_addr[8'(w0 + i)]), i);
      check($sformatf("frame_data%0d", i), 32'(log_data[8'(w0 + i)]), i + 1);
    end
    check("frame_one_start", 32'(start_count - s0), 32'd1);
    check("start_after_last_write", 32'(last_start_cyc - last_wr_cyc), 32'd1);
    check("done_at_start_ignored", 32'(busy), 32'd1);
    w0 = wr_count;
    send_byte(8'h77, 1'b1);
    check("wait_drops_byte", 32'(wr_count - w0), 32'd0);
    check("wait_overrun", 32'(overrun), 32'd1);
    pulse_done();
    check("busy_cleared", 32'(busy), 32'd0);
    send_byte(8'h20, 1'b1);
    check("next_frame_addr", 32'(log_addr[w0[7:0]]), 32'd0);

    // One-cycle glitch produces nothing.
    do_reset();
    w0 = wr_count;
    uart_rx = 1'b0;
    tick(1);
    uart_rx = 1'b1;
    tick(60);
    check("glitch_no_write", 32'(wr_count - w0), 32'd0);
    check("glitch_no_fe", 32'(framing_error), 32'd0);

    // Reset mid-frame discards partial image.
    send_byte(8'h31, 1'b1);
    send_byte(8'h32, 1'b1);
    resetn = 1'b0;
    tick(1);
    check("midreset_outputs",
          {17'd0, mem_wr_data, mem_wr_en, mem_wr_addr, nn_start, busy, framing_error, overrun},
          32'd0);
    tick(1);
    resetn = 1'b1;
    tick(2);
    w0 = wr_count;
    s0 = start_count;
    for (int i = 0; i < 3; i++) send_byte(8'(8'h40 + i), 1'b1);
    check("midreset_no_early_start", 32'(start_count - s0), 32'd0);
    send_byte(8'h43, 1'b1);
    check("midreset_start", 32'(start_count - s0), 32'd1);
    for (int i = 0; i < 4; i++)
      check($sformatf("midreset_addr%0d", i), 32'(log_addr[8'(w0 + i)]), i);

    // Idle gap in the middle of a frame.
    pulse_done();
    w0 = wr_count;
    s0 = start_count;
    send_byte(8'h51, 1'b1);
    send_byte(8'h52, 1'b1);
    tick(150);
    send_byte(8'h99, 1'b1);
    check("gap_data", 32'(log_data[8'(w0 + 2)]), 32'h99);
`ifdef LOAD_TIMEOUT_EN
    check("gap_addr", 32'(log_addr[8'(w0 + 2)]), 32'd0);
`else
    check("gap_addr", 32'(log_addr[8'(w0 + 2)]), 32'd2);
`endif
    check("gap_no_start", 32'(start_count - s0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/uart_image_loader.md
Name: uart_image_loader

Overview:
- Input-side front end for neural_network: receives one image of NUM_PIXELS 8-bit pixels over a UART line.
- Writes each pixel into the network's input memory through a write port.
- After the last pixel it issues a one-cycle start pulse to the network, then waits for done before accepting the next image.
- Sits between the board RX pin and neural_network, on the same clock as the network.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit period (must be >= 4).
- NUM_PIXELS, 784, pixels per image.
- ADDR_WIDTH, 10, width of the memory write address (2^ADDR_WIDTH >= NUM_PIXELS).
- TIMEOUT_CYCLES, 5000000, inter-byte idle limit used only with LOAD_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  synchronous active-low reset.
- uart_rx  input  1  asynchronous serial input, idle high, 8N1, LSB first.
- nn_done  input  1  completion from neural_network; level or pulse.
- mem_wr_en  output  1  one-cycle write strobe per accepted pixel.
- mem_wr_addr  output  ADDR_WIDTH  pixel index 0..NUM_PIXELS-1.
- mem_wr_data  output  8  received pixel byte.
- nn_start  output  1  one-cycle start pulse to neural_network.
- busy  output  1  high from first pixel accepted until nn_done seen.
- framing_error  output  1  sticky; set on a bad stop bit.
- overrun  output  1  sticky; set when a byte arrives while not loading.

Behaviour:
- Reset (resetn low at clk edge):
  - All outputs 0; both FSMs to IDLE; pixel counter 0.
  - The synchronizer flops reset to 1 (idle line).
  - Reset mid-frame or mid-inference discards the partial image with no further writes or start.
- uart_rx passes through a 2-flop synchronizer before any use.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE: a low synchronized sample moves to RX_START; the bit counter clears.
  - RX_START: at CLKS_PER_BIT/2 cycles, re-sample. If high (glitch), return to RX_IDLE. If low, clear the counter and go to RX_DATA.
  - RX_DATA: sample every CLKS_PER_BIT cycles (mid-bit) and shift in LSB first; 8 samples, then RX_STOP.
  - RX_STOP: sample after CLKS_PER_BIT cycles.
    - High: byte_valid pulses for 1 cycle.
    - Low: no byte_valid; framing_error is set to 1.
    - Either way, return to RX_IDLE once the line reads high.
- Loader FSM states: L_LOAD, L_START, L_WAIT.
  - L_LOAD: on byte_valid, write the byte.
    - mem_wr_en=1, mem_wr_addr=counter, mem_wr_data=byte, all in the cycle after the stop-bit sample (latency 1).
    - busy is set on the first write.
    - The counter increments.
    - If the counter was NUM_PIXELS-1, the counter wraps to 0 and the FSM goes to L_START.
  - L_START: nn_start=1 for exactly one cycle, then L_WAIT.
  - L_WAIT: on nn_done=1, clear busy and go to L_LOAD.
    - nn_done is ignored in L_LOAD and L_START.
    - nn_done coinciding with the nn_start cycle is ignored.
  - A byte_valid in L_START or L_WAIT is dropped (no write) and sets overrun.
- Write addresses are strictly sequential 0..NUM_PIXELS-1; no write to any address >= NUM_PIXELS.
- A framing error does not advance the counter; the next good byte takes the same address.
- framing_error and overrun clear only on reset.

Optional Feature:
- LOAD_TIMEOUT_EN defined:
  - An idle counter runs in L_LOAD while the pixel counter is non-zero.
  - It resets on each byte_valid.
  - On reaching TIMEOUT_CYCLES, the pixel counter returns to 0 and busy clears, so the partial frame is abandoned and the next byte is written to address 0.
  - No start is issued.
- LOAD_TIMEOUT_EN undefined:
  - No idle counter; a partial frame waits indefinitely for its remaining bytes.

Test Plan:
- Byte framing (CLKS_PER_BIT=4, NUM_PIXELS=4): send 0xA5 -> one mem_wr_en with addr 0, data 0xA5; busy=1; nn_start=0.
- Full frame: send 0x01,0x02,0x03,0x04 -> writes at addr 0..3 with matching data; nn_start high exactly one cycle after the 4th write; then nn_done=1 -> busy=0, next byte goes to addr 0.
- Framing error: send 0x55 with the stop bit low, then 0x66 good -> framing_error=1; a single write of 0x66 at addr 0.
- Overrun: complete a frame, hold nn_done=0, send 0x77 -> no write; overrun=1; after nn_done, 0x10 is written at addr 0.
- Glitch and reset: a 1-cycle low pulse on uart_rx produces no byte. Asserting resetn=0 after 2 of 4 bytes clears all outputs; the next frame starts at addr 0 with no nn_start until 4 new bytes arrive.
- LOAD_TIMEOUT_EN (TIMEOUT_CYCLES=100): send 2 bytes, idle 150 cycles, send 0x99 -> 0x99 is written at addr 0; no nn_start occurs.
